// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 registered demultiplexer: default width and select encodings.
package demux_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   localparam logic SEL_OUT0 = 1'b0;
   localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_out_reg.sv
// One output channel: WIDTH-bit data register plus valid flag, cleared asynchronously.
module demux_out_reg #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o,
   output logic             valid_o
);

   logic [Width-1:0] data_d, data_q;
   logic             valid_d, valid_q;

   // A channel that is not loaded this cycle drives zeros rather than holding stale data.
   always_comb begin
      data_d  = '0;
      valid_d = 1'b0;
      if (load_i) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/demux_1to2.sv
// Registered 1-to-2 demultiplexer: routes data_in to the channel chosen by sel, zeros the other.
module demux_1to2
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] data_out0,
   output logic [WIDTH-1:0] data_out1,
   output logic             out_valid0,
   output logic             out_valid1
);

   logic load0, load1;

   // Case-equality matching sends any X/Z on in_valid or sel to the default: nothing loads.
   always_comb begin
      load0 = 1'b0;
      load1 = 1'b0;
      case ({in_valid, sel})
         {1'b1, SEL_OUT0}: load0 = 1'b1;
         {1'b1, SEL_OUT1}: load1 = 1'b1;
         default: ;
      endcase
   end

   demux_out_reg #(
      .Width (WIDTH)
   ) u_out0 (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (load0),
      .data_i  (data_in),
      .data_o  (data_out0),
      .valid_o (out_valid0)
   );

   demux_out_reg #(
      .Width (WIDTH)
   ) u_out1 (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (load1),
      .data_i  (data_in),
      .data_o  (data_out1),
      .valid_o (out_valid1)
   );

endmodule

// File: tb/tb_demux_1to2.sv
// Directed bench for demux_1to2 with a queue scoreboard of expected post-edge outputs.
module tb_demux_1to2;

   localparam int unsigned W = 4;

   typedef struct packed {
      logic [W-1:0] d0;
      logic [W-1:0] d1;
      logic         v0;
      logic         v1;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] data_in;
   logic         sel;
   logic         in_valid;
   logic [W-1:0] data_out0, data_out1;
   logic         out_valid0, out_valid1;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   demux_1to2 #(
      .WIDTH (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .sel        (sel),
      .in_valid   (in_valid),
      .data_out0  (data_out0),
      .data_out1  (data_out1),
      .out_valid0 (out_valid0),
      .out_valid1 (out_valid1)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] d, input logic s, input logic v);
      exp_t e;
      e = '0;
      if (v && !s) begin
         e.d0 = d;
         e.v0 = 1'b1;
      end else if (v && s) begin
         e.d1 = d;
         e.v1 = 1'b1;
      end
      return e;
   endfunction

   task automatic compare(input string tag, input exp_t e);
      checks++;
      assert (data_out0 === e.d0) else begin
         errors++;
         $error("FAIL %s data_out0 got %h want %h", tag, data_out0, e.d0);
      end
      checks++;
      assert (data_out1 === e.d1) else begin
         errors++;
         $error("FAIL %s data_out1 got %h want %h", tag, data_out1, e.d1);
      end
      checks++;
      assert (out_valid0 === e.v0) else begin
         errors++;
         $error("FAIL %s out_valid0 got %b want %b", tag, out_valid0, e.v0);
      end
      checks++;
      assert (out_valid1 === e.v1) else begin
         errors++;
         $error("FAIL %s out_valid1 got %b want %b", tag, out_valid1, e.v1);
      end
      checks++;
      assert (!(out_valid0 && out_valid1)) else begin
         errors++;
         $error("FAIL %s onehot got v0=%b v1=%b want at most one", tag, out_valid0, out_valid1);
      end
   endtask

   task automatic pop_compare(input string tag);
      exp_t e;
      checks++;
      assert (sb_q.size() > 0) else begin
         errors++;
         $error("FAIL %s scoreboard got empty want entry", tag);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         compare(tag, e);
      end
   endtask

   // Drive one word, push its expectation, then check #1 after the sampling edge.
   task automatic step(input string tag, input logic [W-1:0] d, input logic s, input logic v);
      data_in  = d;
      sel      = s;
      in_valid = v;
      sb_q.push_back(model(d, s, v));
      @(posedge clk);
      #1;
      pop_compare(tag);
   endtask

   initial begin
      rst      = 1'b1;
      data_in  = 4'hF;
      sel      = 1'b1;
      in_valid = 1'b1;
      #2;
      compare("reset_no_edge", '0);
      @(negedge clk);
      rst = 1'b0;

      step("route_ch0", 4'd1, 1'b0, 1'b1);
      step("route_ch1", 4'd1, 1'b1, 1'b1);
      #30;
      compare("hold_30", model(4'd1, 1'b1, 1'b1));

      step("alt_a", 4'hA, 1'b0, 1'b1);
      step("alt_5", 4'h5, 1'b1, 1'b1);
      step("alt_c", 4'hC, 1'b0, 1'b1);
      step("full_width", 4'hF, 1'b1, 1'b1);

      step("invalid", 4'h7, 1'b1, 1'b0);
      step("invalid_sel0", 4'h7, 1'b0, 1'b0);

      step("pre_reset_ch1", 4'h9, 1'b1, 1'b1);
      // Present a fresh word, then pulse reset between edges.
      data_in  = 4'h3;
      sel      = 1'b0;
      in_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      compare("async_clear", '0);
      #1;
      rst = 1'b0;
      step("resume", 4'h3, 1'b0, 1'b1);
      step("resume_ch1", 4'h6, 1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
